// File: rtl/phoneme_pkg.sv
// Shared types and helpers for the phoneme playback engine.
package phoneme_pkg;

    localparam int FLASH_ADDR_W = 22;
    localparam int SAMPLE_W     = 8;

    // Playback sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_DATA,
        ST_HOLD,
        ST_SILENT,
        ST_DONE
    } state_t;

    // Flash read handshake states
    typedef enum logic [1:0] {
        RD_IDLE,
        RD_REQ,
        RD_WAIT
    } rd_state_t;

    // Pick one byte out of a little-endian 32-bit flash word
    function automatic logic [SAMPLE_W-1:0] byte_lane(input logic [31:0] word,
                                                      input logic [1:0]  lane);
        logic [SAMPLE_W-1:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/phoneme_flash_rd.sv
// Single-outstanding read master for the phoneme flash.
// A req pulse with a byte address yields one ack pulse carrying that byte.
// Optional macro PHONEME_PLAYER_WORDBUF_EN keeps the last fetched word so
// that sequential bytes from the same word skip the bus entirely.
module phoneme_flash_rd
    import phoneme_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_i,
    input  logic [ADDR_W-1:0]       byte_addr_i,
    input  logic                    flush_i,
    output logic                    ack_o,
    output logic [SAMPLE_W-1:0]     byte_o,
    output logic                    waiting_o,
    output logic                    flash_read_o,
    output logic [FLASH_ADDR_W-1:0] flash_address_o,
    input  logic                    flash_waitrequest_i,
    input  logic                    flash_readdatavalid_i,
    input  logic [DATA_W-1:0]       flash_readdata_i
);

    rd_state_t                rd_q;
    logic                     flash_read_q;
    logic [FLASH_ADDR_W-1:0]  flash_address_q;
    logic [1:0]               lane_q;
    logic                     ack_q;
    logic [SAMPLE_W-1:0]      byte_q;

    logic                     start_rd_d;
    logic                     hit_d;
    logic [SAMPLE_W-1:0]      hit_byte_d;

    // A request still sitting on the port while its ack is out must not
    // launch a second transfer.
    assign start_rd_d = req_i && !ack_q;

`ifdef PHONEME_PLAYER_WORDBUF_EN
    logic [DATA_W-1:0]        word_q;
    logic [FLASH_ADDR_W-1:0]  tag_q;
    logic                     tag_valid_q;

    assign hit_d      = tag_valid_q && (tag_q == byte_addr_i[ADDR_W-1:2]);
    assign hit_byte_d = byte_lane(word_q, byte_addr_i[1:0]);

    // Remember the most recently returned word; a new phoneme forgets it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q      <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
        end else if (flush_i) begin
            tag_valid_q <= 1'b0;
        end else if (rd_q == RD_WAIT && flash_readdatavalid_i) begin
            word_q      <= flash_readdata_i;
            tag_q       <= flash_address_q;
            tag_valid_q <= 1'b1;
        end
    end
`else
    logic unused_flush;

    assign hit_d        = 1'b0;
    assign hit_byte_d   = '0;
    assign unused_flush = flush_i;
`endif

    // Request / accept / data-return handshake with registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q            <= RD_IDLE;
            flash_read_q    <= 1'b0;
            flash_address_q <= '0;
            lane_q          <= '0;
            ack_q           <= 1'b0;
            byte_q          <= '0;
        end else begin
            ack_q <= 1'b0;
            case (rd_q)
                RD_IDLE: begin
                    if (start_rd_d) begin
                        if (hit_d) begin
                            ack_q  <= 1'b1;
                            byte_q <= hit_byte_d;
                        end else begin
                            flash_read_q    <= 1'b1;
                            flash_address_q <= byte_addr_i[ADDR_W-1:2];
                            lane_q          <= byte_addr_i[1:0];
                            rd_q            <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (!flash_waitrequest_i) begin
                        flash_read_q <= 1'b0;
                        rd_q         <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (flash_readdatavalid_i) begin
                        byte_q <= byte_lane(flash_readdata_i[31:0], lane_q);
                        ack_q  <= 1'b1;
                        rd_q   <= RD_IDLE;
                    end
                end
                default: rd_q <= RD_IDLE;
            endcase
        end
    end

    assign ack_o           = ack_q;
    assign byte_o          = byte_q;
    assign waiting_o       = (rd_q == RD_WAIT);
    assign flash_read_o    = flash_read_q;
    assign flash_address_o = flash_address_q;

endmodule

// File: rtl/phoneme_player.sv
// Phoneme playback engine: walks a byte range of flash (or counts out a
// silent pause) and emits one signed 8-bit sample per sample tick.
// Optional macro PHONEME_PLAYER_WORDBUF_EN enables the word buffer in the
// flash reader so only one bus read is needed per four sequential samples.
module phoneme_player
    import phoneme_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       start_address,
    input  logic [ADDR_W-1:0]       end_address,
    input  logic                    silent,
    input  logic                    sample_tick,
    output logic                    flash_read,
    output logic [FLASH_ADDR_W-1:0] flash_address,
    input  logic                    flash_waitrequest,
    input  logic                    flash_readdatavalid,
    input  logic [DATA_W-1:0]       flash_readdata,
    output logic [SAMPLE_W-1:0]     audio_out,
    output logic                    audio_valid,
    output logic                    busy,
    output logic                    done
);

    state_t               state_q;
    logic [ADDR_W-1:0]    ptr_q;
    logic [ADDR_W-1:0]    end_q;
    logic                 tick_pending_q;
    logic [SAMPLE_W-1:0]  sample_buf_q;
    logic [SAMPLE_W-1:0]  audio_q;
    logic                 audio_valid_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 rd_req_d;
    logic                 flush_d;
    logic                 tick_d;
    logic                 last_d;
    logic [ADDR_W-1:0]    ptr_inc_d;
    logic                 rd_ack;
    logic                 rd_waiting;
    logic [SAMPLE_W-1:0]  rd_byte;

    assign rd_req_d  = (state_q == ST_FETCH);
    assign flush_d   = (state_q == ST_IDLE) && start;
    assign tick_d    = sample_tick || tick_pending_q;
    // Using >= rather than == also terminates start>end and wrapped ranges
    assign last_d    = (ptr_q >= end_q);
    assign ptr_inc_d = ptr_q + 1'b1;

    phoneme_flash_rd #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_flash_rd (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .req_i                 (rd_req_d),
        .byte_addr_i           (ptr_q),
        .flush_i               (flush_d),
        .ack_o                 (rd_ack),
        .byte_o                (rd_byte),
        .waiting_o             (rd_waiting),
        .flash_read_o          (flash_read),
        .flash_address_o       (flash_address),
        .flash_waitrequest_i   (flash_waitrequest),
        .flash_readdatavalid_i (flash_readdatavalid),
        .flash_readdata_i      (flash_readdata)
    );

    // Playback sequencer with registered audio/busy/done outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            end_q          <= '0;
            tick_pending_q <= 1'b0;
            sample_buf_q   <= '0;
            audio_q        <= '0;
            audio_valid_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            audio_valid_q <= 1'b0;
            done_q        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tick_pending_q <= 1'b0;
                    if (start) begin
                        ptr_q   <= start_address;
                        end_q   <= end_address;
                        busy_q  <= 1'b1;
                        state_q <= silent ? ST_SILENT : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (sample_tick) begin
                        tick_pending_q <= 1'b1;
                    end
                    if (rd_ack) begin
                        sample_buf_q <= rd_byte;
                        state_q      <= ST_HOLD;
                    end else if (rd_waiting) begin
                        state_q <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (sample_tick) begin
                        tick_pending_q <= 1'b1;
                    end
                    if (rd_ack) begin
                        sample_buf_q <= rd_byte;
                        state_q      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tick_d) begin
                        audio_q        <= sample_buf_q;
                        audio_valid_q  <= 1'b1;
                        tick_pending_q <= 1'b0;
                        if (last_d) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end else begin
                            ptr_q   <= ptr_inc_d;
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_SILENT: begin
                    if (sample_tick) begin
                        audio_q       <= '0;
                        audio_valid_q <= 1'b1;
                        if (last_d) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end else begin
                            ptr_q <= ptr_inc_d;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign audio_out   = audio_q;
    assign audio_valid = audio_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_phoneme_player.sv
// Bench for phoneme_player: flash slave model, tick generator and a
// descriptor-level reference model of the expected sample stream.
module tb_phoneme_player;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] start_address = '0;
    logic [23:0] end_address = '0;
    logic        silent = 1'b0;
    logic        sample_tick = 1'b0;
    logic        flash_waitrequest = 1'b0;
    logic        flash_readdatavalid = 1'b0;
    logic [31:0] flash_readdata = '0;
    logic        flash_read;
    logic [21:0] flash_address;
    logic [7:0]  audio_out;
    logic        audio_valid;
    logic        busy;
    logic        done;

    phoneme_player dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .start_address       (start_address),
        .end_address         (end_address),
        .silent              (silent),
        .sample_tick         (sample_tick),
        .flash_read          (flash_read),
        .flash_address       (flash_address),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdatavalid (flash_readdatavalid),
        .flash_readdata      (flash_readdata),
        .audio_out           (audio_out),
        .audio_valid         (audio_valid),
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // environment state shared between the main sequence and the bus/tick loop
    int          cyc = 0;
    logic [7:0]  got_q[$];
    int          done_cnt = 0;
    int          reads = 0;
    int          read_cycles = 0;
    int          addr_jumps = 0;
    int          first_valid_cyc = -1;
    int          last_rdv_cyc = -1;
    int          tick_period = 100;
    int          tick_cnt = 0;
    bit          tick_en = 1'b1;
    bit          tick_force = 1'b0;
    bit          rand_wait = 1'b0;
    int          stall_cnt = 0;
    bit          hold_data = 1'b0;
    bit          stray_rdv = 1'b0;
    int          lat_cnt = 0;
    logic [21:0] acc_addr = '0;
    bit          held_prev = 1'b0;
    logic [21:0] held_addr = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // flash contents: one directed word, hashed data everywhere else
    function automatic logic [31:0] mem_word(input logic [21:0] w);
        if (w == 22'h40) return 32'h44332211;
        return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [23:0] p);
        logic [31:0] wd;
        wd = mem_word(p[23:2]);
        return 8'(wd >> (8 * int'(p[1:0])));
    endfunction

    // Bus slave, tick source and output monitor, all evaluated at negedge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (audio_valid) begin
                got_q.push_back(audio_out);
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (done) done_cnt++;
            if (flash_read) read_cycles++;
            if (flash_read && held_prev && flash_address !== held_addr) addr_jumps++;

            if (tick_force) begin
                sample_tick = 1'b1;
                tick_force = 1'b0;
            end else if (tick_en) begin
                tick_cnt++;
                if (tick_cnt >= tick_period) begin
                    sample_tick = 1'b1;
                    tick_cnt = 0;
                end else begin
                    sample_tick = 1'b0;
                end
            end else begin
                sample_tick = 1'b0;
            end

            flash_readdatavalid = 1'b0;
            if (stray_rdv) begin
                flash_readdatavalid = 1'b1;
                flash_readdata = $urandom;
                stray_rdv = 1'b0;
            end else if (lat_cnt > 0 && !hold_data) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    flash_readdatavalid = 1'b1;
                    flash_readdata = mem_word(acc_addr);
                    last_rdv_cyc = cyc;
                end
            end

            if (stall_cnt > 0) begin
                flash_waitrequest = 1'b1;
                stall_cnt--;
            end else begin
                flash_waitrequest = rand_wait && ($urandom_range(0, 3) == 0);
            end

            if (flash_read && !flash_waitrequest && lat_cnt == 0) begin
                reads++;
                acc_addr = flash_address;
                lat_cnt = $urandom_range(1, 3);
                held_prev = 1'b0;
            end else begin
                held_prev = flash_read;
                held_addr = flash_address;
            end
        end
    end

    task automatic clear_obs();
        got_q.delete();
        done_cnt = 0;
        reads = 0;
        read_cycles = 0;
        addr_jumps = 0;
        first_valid_cyc = -1;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int waited;
        waited = 0;
        while (done_cnt == 0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (done_cnt == 0) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Play one descriptor and compare against the reference stream
    task automatic run_phoneme(input logic [23:0] s, input logic [23:0] e,
                               input logic sil, input int period, input string tag);
        int          n;
        int          exp_reads;
        int          lim;
        logic [23:0] p;
        logic [23:0] pp;
        logic [7:0]  exp_q[$];

        n = (s > e) ? 1 : int'(e - s) + 1;
        for (int i = 0; i < n; i++) begin
            p = s + 24'(i);
            exp_q.push_back(sil ? 8'h00 : mem_byte(p));
        end
`ifdef PHONEME_PLAYER_WORDBUF_EN
        exp_reads = sil ? 0 : 1;
        for (int i = 1; i < n; i++) begin
            p  = s + 24'(i);
            pp = s + 24'(i - 1);
            if (!sil && p[23:2] != pp[23:2]) exp_reads++;
        end
`else
        exp_reads = sil ? 0 : n;
`endif

        tick_period = period;
        @(negedge clk);
        clear_obs();
        start_address = s;
        end_address = e;
        silent = sil;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (n >= 3) begin
            repeat (2) @(negedge clk);
            check_eq({tag, "_busy"}, 32'(busy), 32'd1);
            start_address = 24'h000555;
            end_address = 24'h000560;
            silent = ~sil;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(n * (period + 12) + 200, tag);
        repeat (3) @(negedge clk);

        check_eq({tag, "_nsamples"}, 32'(got_q.size()), 32'(n));
        lim = (got_q.size() < n) ? got_q.size() : n;
        for (int i = 0; i < lim; i++)
            check_eq($sformatf("%s_sample%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check_eq({tag, "_reads"}, 32'(reads), 32'(exp_reads));
        check_eq({tag, "_done"}, 32'(done_cnt), 32'd1);
        check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
        check_eq({tag, "_addr_stable"}, 32'(addr_jumps), 32'd0);
        if (sil) check_eq({tag, "_no_flash"}, 32'(read_cycles), 32'd0);
        $display("phoneme %s: start=%06h end=%06h silent=%0d samples=%0d reads=%0d",
                 tag, s, e, sil, got_q.size(), reads);
    endtask

    initial begin
        logic [23:0] rs;
        logic [23:0] re;
        logic        rsil;
        int          waited;

        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_flash_read", 32'(flash_read), 32'd0);
        check_eq("rst_audio_out", 32'(audio_out), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // directed playback from word 0x40, zero-wait slave, slow ticks
        rand_wait = 1'b0;
        run_phoneme(24'h000100, 24'h000103, 1'b0, 100, "word40");
        run_phoneme(24'h000100, 24'h000103, 1'b0, 20, "word40_again");

        // silent pause of 73 ticks
        run_phoneme(24'h000000, 24'd72, 1'b1, 10, "silent73");

        // start > end plays exactly one sample
        run_phoneme(24'h000200, 24'h0001FF, 1'b0, 15, "start_gt_end");
        run_phoneme(24'hFFFFFF, 24'h000001, 1'b0, 15, "top_wrap");
        run_phoneme(24'hFFFFFE, 24'hFFFFFF, 1'b0, 15, "top_pair");

        // long stall with a single tick landing mid-stall
        tick_en = 1'b0;
        @(negedge clk);
        clear_obs();
        stall_cnt = 22;
        start_address = 24'h000123;
        end_address = 24'h000123;
        silent = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("stall_read_held", 32'(flash_read), 32'd1);
        tick_force = 1'b1;
        wait_done(200, "stall");
        repeat (2) @(negedge clk);
        check_eq("stall_nsamples", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check_eq("stall_sample", 32'(got_q[0]), 32'(mem_byte(24'h000123)));
        check_eq("stall_addr_stable", 32'(addr_jumps), 32'd0);
        check_eq("stall_out_soon", 32'((first_valid_cyc > last_rdv_cyc) &&
                                      (first_valid_cyc - last_rdv_cyc <= 4)), 32'd1);
        $display("phoneme stall: sample after %0d cycles from data", first_valid_cyc - last_rdv_cyc);
        tick_en = 1'b1;

        // reset while a read is outstanding
        hold_data = 1'b1;
        @(negedge clk);
        clear_obs();
        start_address = 24'h000300;
        end_address = 24'h000305;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (lat_cnt == 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_eq("mid_fetch_reached", 32'(lat_cnt > 0), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_flash_read", 32'(flash_read), 32'd0);
        check_eq("midrst_flash_address", 32'(flash_address), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_audio_valid", 32'(audio_valid), 32'd0);
        check_eq("midrst_audio_out", 32'(audio_out), 32'd0);
        hold_data = 1'b0;
        lat_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        stray_rdv = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("stray_rdv_samples", 32'(got_q.size()), 32'd0);
        check_eq("stray_rdv_busy", 32'(busy), 32'd0);
        $display("phoneme reset_mid_fetch: outputs cleared, stray data ignored");
        run_phoneme(24'h000300, 24'h000305, 1'b0, 12, "after_reset");

        // randomized descriptors with a randomly stalling slave
        rand_wait = 1'b1;
        for (int k = 0; k < 12; k++) begin
            rsil = ($urandom_range(0, 3) == 0);
            if (rsil) begin
                rs = 24'h0;
                re = 24'($urandom_range(0, 20));
            end else begin
                rs = 24'($urandom_range(0, 24'h3FF));
                if ($urandom_range(0, 5) == 0) re = rs - 24'd1;
                else re = rs + 24'($urandom_range(0, 9));
            end
            run_phoneme(rs, re, rsil, $urandom_range(6, 40), $sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/phoneme_player.md
Name: phoneme_player

Overview:
- Consumer end of the phoneme address lookup. Accepts a {start_address, end_address, silent} descriptor with a start pulse.
- Non-silent: walks flash byte addresses start..end, fetching one 32-bit word per sample over an Avalon-MM-style read master, and emits one signed 8-bit sample per sample_tick.
- Silent: emits zero samples for (end-start+1) ticks with no flash traffic.
- Pulses done on completion so the sequencer can issue the next phoneme.

Parameters:
- ADDR_W, 24, width of start/end/pointer byte addresses.
- DATA_W, 32, flash read data width; fixed at 4 byte lanes.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse: latch descriptor, begin playback (ignored while busy)
- start_address  input  24  first byte address (silent: always 0)
- end_address  input  24  last byte address inclusive (silent: tick count minus 1)
- silent  input  1  1 = pause phoneme, no flash reads
- sample_tick  input  1  one-cycle sample-rate strobe (e.g. 8 kHz)
- flash_read  output  1  read request
- flash_address  output  22  word address = pointer[23:2]
- flash_waitrequest  input  1  slave stall; request held while high
- flash_readdatavalid  input  1  read data valid
- flash_readdata  input  32  read data, byte 0 in [7:0]
- audio_out  output  8  signed sample, held between ticks
- audio_valid  output  1  one-cycle pulse when audio_out updates
- busy  output  1  high from cycle after accepted start until done
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n low): state=IDLE; flash_read=0, flash_address=0, audio_out=0, audio_valid=0, busy=0, done=0, tick_pending=0. Reset mid-fetch drops flash_read immediately; late readdatavalid in IDLE is ignored.
- States: IDLE, FETCH, WAIT_DATA, HOLD, SILENT, DONE.
- IDLE:
  - start=1 latches ptr<=start_address, end<=end_address, mode<=silent, then goes to SILENT if silent, else FETCH. busy rises next cycle.
- FETCH:
  - flash_read=1, flash_address=ptr[23:2].
  - Stay while flash_waitrequest=1.
  - Request accepted on the cycle with waitrequest=0, then WAIT_DATA with flash_read=0. Exactly one read is outstanding.
- WAIT_DATA:
  - On readdatavalid, capture byte lane ptr[1:0] into sample_buf, then HOLD.
- HOLD:
  - On (sample_tick | tick_pending): audio_out<=sample_buf, audio_valid=1 for one cycle, tick_pending cleared.
  - If ptr>=end, go to DONE; else ptr<=ptr+1 and go to FETCH.
- SILENT:
  - Per tick: audio_out<=0, audio_valid pulse.
  - If ptr>=end, go to DONE; else ptr++. Start 0, end 72 gives 73 valid pulses.
- DONE: done=1 for one cycle, busy falls, then IDLE.
- tick_pending:
  - Set by sample_tick in FETCH/WAIT_DATA; a tick is never lost while a fetch is in flight.
  - A second tick while pending is dropped.
  - Cleared when consumed or in IDLE.
- start_address>end_address: exactly one sample (start_address) is played, then done.
- start while busy: ignored, no descriptor change.
- ptr arithmetic is 24-bit. 24'hFFFFFF with a larger end wraps to 0; this is the caller's error and must not hang.

Optional Feature:
- Macro PHONEME_PLAYER_WORDBUF_EN.
- Defined:
  - Keep last fetched word plus a valid tag for ptr[23:2].
  - In FETCH, a tag hit skips the bus read and goes straight to HOLD with the cached byte. Sequential playback then reads flash once per 4 samples.
  - Tag invalidated on reset and on each accepted start.
- Undefined: one flash read per sample, no word register.

Decomposition:
- Package phoneme_pkg: state enum, FLASH_ADDR_W=22, SAMPLE_W=8, and a byte-lane select function (word, lane) returning 8 bits.
- One natural sub-module, phoneme_flash_rd: FETCH/WAIT_DATA handshake plus optional word buffer. It takes (req, byte_addr) and returns (ack, byte).

Test Plan:
- Non-silent play: start start=0x000100 end=0x000103, mem word 0x40 = 0x44332211, zero-wait slave, tick every 100 clk -> exactly 4 flash reads, audio_out 0x11,0x22,0x33,0x44 with 4 audio_valid pulses, one done, busy low after.
- Silent: start silent=1 start=0 end=72, tick every 10 clk -> 73 audio_valid pulses all 0, flash_read never asserted, done after 73rd tick.
- Waitrequest stall: waitrequest high 20 cycles with a tick arriving mid-stall -> flash_address stable while flash_read held, tick_pending set, sample output on the cycle after data returns to HOLD.
- start>end: start=0x200 end=0x1FF -> single sample 0x200 output, then done.
- Reset mid-fetch: rst_n low during WAIT_DATA -> all outputs 0 immediately; stray readdatavalid ignored; new start plays normally.
- PHONEME_PLAYER_WORDBUF_EN: repeat test 1 -> one flash read total, same four samples; second start at same address -> first read not skipped because the tag was invalidated.
